dl_pri_arbiter_4p: RTL and testbench

DL_PRI_ARBITER_4P -- requirements
Module: dl_pri_arbiter_4p

---
 rtl/design_lib_pkg.sv | 23 ++
 rtl/dl_pri_encoder_4p2p.sv | 33 +++
 rtl/dl_pri_arbiter_4p.sv | 116 +++++++++++
 tb/tb_dl_pri_arbiter_4p.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/design_lib_pkg.sv
// ============================================================================
//  Module   : design_lib_pkg
//  Brief    : Shared constants and state encodings for the design_lib blocks.
//  Revision : 1.0
// ============================================================================
`ifndef DESIGN_LIB_PKG_SV
`define DESIGN_LIB_PKG_SV
`default_nettype none

package design_lib_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

endpackage : design_lib_pkg

`default_nettype wire
`endif

// File: rtl/dl_pri_encoder_4p2p.sv
// ============================================================================
//  Module   : dl_pri_encoder_4p2p
//  Brief    : 4-input priority encoder, highest set index wins.
//  Revision : 1.0
// ============================================================================
`ifndef DL_PRI_ENCODER_4P2P_SV
`define DL_PRI_ENCODER_4P2P_SV
`default_nettype none

module dl_pri_encoder_4p2p
   import design_lib_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            idx = i[IDX_W-1:0];
            vld = 1'b1;
         end
      end
   end

endmodule : dl_pri_encoder_4p2p

`default_nettype wire
`endif

// File: rtl/dl_pri_arbiter_4p.sv
// ============================================================================
//  Module   : dl_pri_arbiter_4p
//  Brief    : 4-port fixed-priority arbiter with pending register and
//             valid/ready grant handshake, no pre-emption of a held grant.
//  Revision : 1.0
// ============================================================================
`ifndef DL_PRI_ARBITER_4P_SV
`define DL_PRI_ARBITER_4P_SV
`default_nettype none

module dl_pri_arbiter_4p
   import design_lib_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_set,
   input  logic             flush,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt_oh,
   input  logic             gnt_rdy,
   output logic [N_REQ-1:0] pend
);

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [IDX_W-1:0] r_gnt_idx;
   logic [IDX_W-1:0] w_gnt_idx_nxt;
   logic [N_REQ-1:0] r_pend;
   logic [N_REQ-1:0] w_pend_nxt;
   logic [N_REQ-1:0] w_gnt_oh;
   logic [N_REQ-1:0] w_clr;
   logic [N_REQ-1:0] w_pend_masked;
   logic             w_hs;
   logic [IDX_W-1:0] w_enc_idx;
   logic             w_enc_vld;

   assign gnt_vld = (r_state == ARB_GRANT);
   assign gnt_idx = r_gnt_idx;
   assign gnt_oh  = w_gnt_oh;
   assign pend    = r_pend;

   assign w_hs = gnt_vld & gnt_rdy;

   always_comb begin
      w_gnt_oh = '0;
      if (gnt_vld) begin
         w_gnt_oh[r_gnt_idx] = 1'b1;
      end
   end

   // The bit being handed off is hidden from the encoder so the next grant
   // can be loaded on the same edge without a bubble.
   assign w_clr         = w_hs ? w_gnt_oh : '0;
   assign w_pend_masked = r_pend & ~w_clr;

   dl_pri_encoder_4p2p u_enc (
      .req (w_pend_masked),
      .idx (w_enc_idx),
      .vld (w_enc_vld)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_idx_nxt = r_gnt_idx;
      w_pend_nxt    = w_pend_masked | req_set;

      case (r_state)
         ARB_IDLE: begin
            if (w_enc_vld) begin
               w_state_nxt   = ARB_GRANT;
               w_gnt_idx_nxt = w_enc_idx;
            end
         end
         ARB_GRANT: begin
            if (w_hs) begin
               if (w_enc_vld) begin
                  w_gnt_idx_nxt = w_enc_idx;
               end else begin
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase

      if (flush) begin
         w_state_nxt = ARB_IDLE;
         w_pend_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ARB_IDLE;
         r_gnt_idx <= '0;
         r_pend    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
         r_pend    <= w_pend_nxt;
      end
   end

   a_oh_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt_oh));

   a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (gnt_vld && !gnt_rdy && !flush) |=> (gnt_vld && $stable(gnt_idx)));

endmodule : dl_pri_arbiter_4p

`default_nettype wire
`endif

// File: tb/tb_dl_pri_arbiter_4p.sv
// ============================================================================
//  Module   : tb_dl_pri_arbiter_4p
//  Brief    : Self-checking bench for dl_pri_arbiter_4p.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dl_pri_arbiter_4p;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_set;
   logic       flush;
   logic       gnt_vld;
   logic [1:0] gnt_idx;
   logic [3:0] gnt_oh;
   logic       gnt_rdy;
   logic [3:0] pend;

   int n_tests = 0;
   int n_fail  = 0;

   dl_pri_arbiter_4p dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_set (req_set),
      .flush   (flush),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_oh  (gnt_oh),
      .gnt_rdy (gnt_rdy),
      .pend    (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       fl;
      logic       rdy;
      logic       e_vld;
      logic [1:0] e_idx;
      logic [3:0] e_oh;
      logic [3:0] e_pend;
   } vec_t;

   vec_t vec [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] hi_idx(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) r = i[1:0];
      end
      return r;
   endfunction

   logic [3:0] m_pend;
   logic       old_vld;
   logic [1:0] old_idx;
   logic       hs;
   logic [3:0] clr;
   logic [3:0] elig;
   logic       e_vld;
   logic [1:0] e_idx;
   logic [3:0] e_oh;
   logic [3:0] rq;

   initial begin
      // Rows: inputs applied before an edge, outputs expected just after it.
      vec[0]  = '{4'b0101, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0101};
      vec[1]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0101};
      vec[2]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001};
      vec[3]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vec[4]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001};
      vec[5]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
      vec[6]  = '{4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b1001};
      vec[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b1001};
      vec[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000};
      vec[9]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b1000};
      vec[10] = '{4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010};
      vec[11] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010};
      vec[12] = '{4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010};
      vec[13] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010};
      vec[14] = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vec[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vec[16] = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0110};
      vec[17] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0110};

      rst_n   = 1'b0;
      req_set = 4'b0;
      flush   = 1'b0;
      gnt_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld",  {31'd0, gnt_vld}, 32'd0);
      chk("rst_idx",  {30'd0, gnt_idx}, 32'd0);
      chk("rst_oh",   {28'd0, gnt_oh},  32'd0);
      chk("rst_pend", {28'd0, pend},    32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         req_set = vec[i].req;
         flush   = vec[i].fl;
         gnt_rdy = vec[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_vld", i),  {31'd0, gnt_vld}, {31'd0, vec[i].e_vld});
         chk($sformatf("vec%0d_oh", i),   {28'd0, gnt_oh},  {28'd0, vec[i].e_oh});
         chk($sformatf("vec%0d_pend", i), {28'd0, pend},    {28'd0, vec[i].e_pend});
         if (vec[i].e_vld)
            chk($sformatf("vec%0d_idx", i), {30'd0, gnt_idx}, {30'd0, vec[i].e_idx});
      end
      req_set = 4'b0;
      flush   = 1'b0;
      gnt_rdy = 1'b0;

      // Asynchronous reset between edges while a grant is held.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld",  {31'd0, gnt_vld}, 32'd0);
      chk("arst_oh",   {28'd0, gnt_oh},  32'd0);
      chk("arst_pend", {28'd0, pend},    32'd0);
      chk("arst_idx",  {30'd0, gnt_idx}, 32'd0);
      #2 rst_n = 1'b1;
      req_set = 4'b1000;
      @(posedge clk);
      #1;
      chk("post_rst_pend", {28'd0, pend},    32'h8);
      chk("post_rst_vld",  {31'd0, gnt_vld}, 32'd0);
      req_set = 4'b0;
      @(posedge clk);
      #1;
      chk("post_rst_gvld", {31'd0, gnt_vld}, 32'd1);
      chk("post_rst_gidx", {30'd0, gnt_idx}, 32'd3);
      gnt_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_done_vld",  {31'd0, gnt_vld}, 32'd0);
      chk("post_rst_done_pend", {28'd0, pend},    32'd0);

      // Random traffic against an independent cycle model.
      m_pend = 4'b0;
      for (int c = 0; c < 10000; c++) begin
         rq = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         req_set = rq;
         gnt_rdy = 1'($urandom_range(0, 1));
         old_vld = gnt_vld;
         old_idx = gnt_idx;
         hs      = old_vld & gnt_rdy;
         clr     = hs ? (4'b0001 << old_idx) : 4'b0000;
         elig    = m_pend & ~clr;
         if (hs) chk("rnd_hs_pending", {31'd0, m_pend[old_idx]}, 32'd1);
         @(posedge clk);
         #1;
         if (!old_vld || hs) begin
            e_vld = (elig != 4'b0);
            e_idx = hi_idx(elig);
         end else begin
            e_vld = 1'b1;
            e_idx = old_idx;
         end
         m_pend = elig | rq;
         e_oh   = e_vld ? (4'b0001 << e_idx) : 4'b0000;
         chk("rnd_vld",  {31'd0, gnt_vld}, {31'd0, e_vld});
         chk("rnd_oh",   {28'd0, gnt_oh},  {28'd0, e_oh});
         chk("rnd_pend", {28'd0, pend},    {28'd0, m_pend});
         if (e_vld) chk("rnd_idx", {30'd0, gnt_idx}, {30'd0, e_idx});
      end

      // Drain: everything still pending must be granted within a bounded time.
      req_set = 4'b0;
      gnt_rdy = 1'b1;
      for (int c = 0; c < 12 && (pend != 4'b0 || gnt_vld); c++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_pend", {28'd0, pend},    32'd0);
      chk("drain_vld",  {31'd0, gnt_vld}, 32'd0);
      gnt_rdy = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_dl_pri_arbiter_4p

`default_nettype wire
